// File: rtl/pc_gen.sv
// Fetch PC register with priority redirect/stall/advance and an optional return-address stack.
// Define PC_RAS_EN to build the RAS; without it pred_call/pred_ret are ignored and the flags are tied.
module pc_gen #(
  parameter int                ADDR_W     = 32,
  parameter int                STALL_W    = 6,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                INST_BYTES = 4,
  parameter int                RAS_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_state,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               pred_call,
  input  logic               pred_ret,
  input  logic               ex_flag,
  input  logic [ADDR_W-1:0]  ex_target,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               ras_empty,
  output logic               ras_full
);

  logic [ADDR_W-1:0] pc_nxt;

`ifdef PC_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top_ptr, top_ptr_nxt, ras_waddr;
  logic [CNT_W-1:0]  ras_cnt, ras_cnt_nxt;
  logic              ras_we;
  logic [ADDR_W-1:0] ret_addr;
  logic              ras_has;
  logic              unused_stall;

  assign unused_stall = ^stall_state[STALL_W-1:1];
  assign ret_addr     = pc_out + ADDR_W'(INST_BYTES);
  assign ras_has      = (ras_cnt != '0);

  always_comb begin
    pc_nxt      = pc_out;
    top_ptr_nxt = top_ptr;
    ras_cnt_nxt = ras_cnt;
    ras_we      = 1'b0;
    ras_waddr   = top_ptr;
    if (ex_flag) begin
      pc_nxt      = ex_target;
      ras_cnt_nxt = '0;
    end else if (!stall_state[0]) begin
      pc_nxt = pc;
      // A swap with an empty stack degenerates to a plain push.
      if (pred_call && (!pred_ret || !ras_has)) begin
        top_ptr_nxt = top_ptr + PTR_W'(1);
        ras_we      = 1'b1;
        ras_waddr   = top_ptr + PTR_W'(1);
        if (ras_cnt != CNT_W'(RAS_DEPTH))
          ras_cnt_nxt = ras_cnt + CNT_W'(1);
      end else if (pred_ret && ras_has) begin
        pc_nxt = ras_mem[top_ptr];
        if (pred_call) begin
          ras_we = 1'b1;
        end else begin
          top_ptr_nxt = top_ptr - PTR_W'(1);
          ras_cnt_nxt = ras_cnt - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out    <= RESET_PC;
      top_ptr   <= '0;
      ras_cnt   <= '0;
      ras_empty <= 1'b1;
      ras_full  <= 1'b0;
    end else begin
      pc_out    <= pc_nxt;
      top_ptr   <= top_ptr_nxt;
      ras_cnt   <= ras_cnt_nxt;
      ras_empty <= (ras_cnt_nxt == '0);
      ras_full  <= (ras_cnt_nxt == CNT_W'(RAS_DEPTH));
    end
  end

  // Stack contents are plain data: no reset, stale entries beyond the count are never read.
  always_ff @(posedge clk) begin
    if (ras_we)
      ras_mem[ras_waddr] <= ret_addr;
  end

`else
  logic unused_in;

  assign unused_in = ^stall_state[STALL_W-1:1] ^ pred_call ^ pred_ret;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;

  always_comb begin
    pc_nxt = pc;
    if (ex_flag)
      pc_nxt = ex_target;
    else if (stall_state[0])
      pc_nxt = pc_out;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pc_out <= RESET_PC;
    else
      pc_out <= pc_nxt;
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vector table followed by a random phase checked against a queue-based stack model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_state;
  logic [31:0] pc;
  logic        pred_call;
  logic        pred_ret;
  logic        ex_flag;
  logic [31:0] ex_target;
  logic [31:0] pc_out;
  logic        ras_empty;
  logic        ras_full;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk         (clk),
    .rst         (rst),
    .stall_state (stall_state),
    .pc          (pc),
    .pred_call   (pred_call),
    .pred_ret    (pred_ret),
    .ex_flag     (ex_flag),
    .ex_target   (ex_target),
    .pc_out      (pc_out),
    .ras_empty   (ras_empty),
    .ras_full    (ras_full)
  );

  typedef struct {
    logic        rst;
    logic [5:0]  stall;
    logic [31:0] pc;
    logic        call;
    logic        ret;
    logic        ex;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic [31:0] e_pc_n;
    logic        e_emp;
    logic        e_full;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        emp;
    logic        full;
    int          id;
  } exp_t;

  vec_t        tv[$];
  exp_t        sb[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  function automatic vec_t mk(logic r, logic [5:0] st, logic [31:0] p, logic c, logic rt,
                              logic e, logic [31:0] t, logic [31:0] ep, logic [31:0] epn,
                              logic em, logic fu);
    vec_t v;
    v.rst = r; v.stall = st; v.pc = p; v.call = c; v.ret = rt; v.ex = e; v.tgt = t;
    v.e_pc = ep; v.e_pc_n = epn; v.e_emp = em; v.e_full = fu;
    return v;
  endfunction

  task automatic model_step(logic r, logic [5:0] st, logic [31:0] p, logic c, logic rt,
                            logic e, logic [31:0] t);
    logic [31:0] ra;
    ra = m_pc + 32'd4;
    if (r) begin
      m_pc = 32'h0;
      m_ras.delete();
    end else if (e) begin
      m_pc = t;
      m_ras.delete();
    end else if (!st[0]) begin
`ifdef PC_RAS_EN
      if (c && rt && m_ras.size() > 0) begin
        m_pc = m_ras[m_ras.size()-1];
        m_ras[m_ras.size()-1] = ra;
      end else if (c) begin
        m_pc = p;
        m_ras.push_back(ra);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end else if (rt && m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
      end else begin
        m_pc = p;
      end
`else
      m_pc = p;
`endif
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    n_cmp++;
    if (pc_out !== e.pc) begin
      n_fail++;
      $display("FAIL pc_out step %0d: got 0x%08h want 0x%08h", e.id, pc_out, e.pc);
    end
    n_cmp++;
    if (ras_empty !== e.emp) begin
      n_fail++;
      $display("FAIL ras_empty step %0d: got %b want %b", e.id, ras_empty, e.emp);
    end
    n_cmp++;
    if (ras_full !== e.full) begin
      n_fail++;
      $display("FAIL ras_full step %0d: got %b want %b", e.id, ras_full, e.full);
    end
  endtask

  task automatic drive(logic r, logic [5:0] st, logic [31:0] p, logic c, logic rt,
                       logic e, logic [31:0] t);
    rst = r; stall_state = st; pc = p; pred_call = c; pred_ret = rt; ex_flag = e; ex_target = t;
    model_step(r, st, p, c, rt, e, t);
  endtask

  initial begin
    exp_t x;
    rst = 1'b1; stall_state = '0; pc = '0; pred_call = 1'b0; pred_ret = 1'b0;
    ex_flag = 1'b0; ex_target = '0; m_pc = '0;

    //            rst stall  pc            c  r  ex tgt           e_pc (RAS)    e_pc (no RAS) emp full
    tv.push_back(mk(1, 6'h00, 32'h0,        0, 0, 1, 32'h80,       32'h0,        32'h0,        1, 0));
    tv.push_back(mk(0, 6'h00, 32'h4,        0, 0, 0, 32'h0,        32'h4,        32'h4,        1, 0));
    tv.push_back(mk(0, 6'h00, 32'h0,        0, 0, 1, 32'h100,      32'h100,      32'h100,      1, 0));
    tv.push_back(mk(0, 6'h01, 32'h104,      0, 0, 0, 32'h0,        32'h100,      32'h100,      1, 0));
    tv.push_back(mk(0, 6'h01, 32'h104,      0, 0, 1, 32'h200,      32'h200,      32'h200,      1, 0));
    tv.push_back(mk(0, 6'h01, 32'h500,      1, 0, 0, 32'h0,        32'h200,      32'h200,      1, 0));
    tv.push_back(mk(0, 6'h3E, 32'h100,      0, 0, 0, 32'h0,        32'h100,      32'h100,      1, 0));
    tv.push_back(mk(0, 6'h00, 32'h400,      1, 0, 0, 32'h0,        32'h400,      32'h400,      0, 0));
    tv.push_back(mk(0, 6'h00, 32'h420,      0, 0, 0, 32'h0,        32'h420,      32'h420,      0, 0));
    tv.push_back(mk(0, 6'h00, 32'h424,      0, 1, 0, 32'h0,        32'h104,      32'h424,      1, 0));
    tv.push_back(mk(0, 6'h00, 32'h0,        0, 0, 1, 32'h10,       32'h10,       32'h10,       1, 0));
    tv.push_back(mk(0, 6'h00, 32'h20,       1, 0, 0, 32'h0,        32'h20,       32'h20,       0, 0));
    tv.push_back(mk(0, 6'h00, 32'h30,       1, 0, 0, 32'h0,        32'h30,       32'h30,       0, 0));
    tv.push_back(mk(0, 6'h00, 32'h40,       1, 0, 0, 32'h0,        32'h40,       32'h40,       0, 0));
    tv.push_back(mk(0, 6'h00, 32'h50,       1, 0, 0, 32'h0,        32'h50,       32'h50,       0, 1));
    tv.push_back(mk(0, 6'h00, 32'h60,       1, 0, 0, 32'h0,        32'h60,       32'h60,       0, 1));
    tv.push_back(mk(0, 6'h00, 32'h900,      0, 1, 0, 32'h0,        32'h54,       32'h900,      0, 0));
    tv.push_back(mk(0, 6'h00, 32'h904,      0, 1, 0, 32'h0,        32'h44,       32'h904,      0, 0));
    tv.push_back(mk(0, 6'h00, 32'h908,      0, 1, 0, 32'h0,        32'h34,       32'h908,      0, 0));
    tv.push_back(mk(0, 6'h00, 32'h90C,      0, 1, 0, 32'h0,        32'h24,       32'h90C,      1, 0));
    tv.push_back(mk(0, 6'h00, 32'h910,      0, 1, 0, 32'h0,        32'h910,      32'h910,      1, 0));
    tv.push_back(mk(0, 6'h00, 32'h0,        0, 0, 1, 32'h100,      32'h100,      32'h100,      1, 0));
    tv.push_back(mk(0, 6'h00, 32'h300,      1, 0, 0, 32'h0,        32'h300,      32'h300,      0, 0));
    tv.push_back(mk(0, 6'h01, 32'h111,      0, 1, 0, 32'h0,        32'h300,      32'h300,      0, 0));
    tv.push_back(mk(0, 6'h00, 32'h700,      1, 1, 0, 32'h0,        32'h104,      32'h700,      0, 0));
    tv.push_back(mk(0, 6'h00, 32'h800,      0, 1, 0, 32'h0,        32'h304,      32'h800,      1, 0));
    tv.push_back(mk(0, 6'h00, 32'h600,      1, 1, 0, 32'h0,        32'h600,      32'h600,      0, 0));
    tv.push_back(mk(0, 6'h00, 32'h0,        1, 1, 1, 32'h40,       32'h40,       32'h40,       1, 0));
    tv.push_back(mk(0, 6'h00, 32'h44,       0, 1, 0, 32'h0,        32'h44,       32'h44,       1, 0));
    tv.push_back(mk(0, 6'h00, 32'h0,        0, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 0));
    tv.push_back(mk(0, 6'h00, 32'h8,        1, 0, 0, 32'h0,        32'h8,        32'h8,        0, 0));
    tv.push_back(mk(0, 6'h00, 32'hC,        0, 1, 0, 32'h0,        32'h0,        32'hC,        1, 0));
    tv.push_back(mk(0, 6'h00, 32'h20,       1, 0, 0, 32'h0,        32'h20,       32'h20,       0, 0));
    tv.push_back(mk(1, 6'h00, 32'h99,       1, 0, 0, 32'h0,        32'h0,        32'h0,        1, 0));
    tv.push_back(mk(0, 6'h00, 32'h30,       0, 1, 0, 32'h0,        32'h30,       32'h30,       1, 0));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      check_out();
      drive(tv[i].rst, tv[i].stall, tv[i].pc, tv[i].call, tv[i].ret, tv[i].ex, tv[i].tgt);
`ifdef PC_RAS_EN
      x.pc = tv[i].e_pc; x.emp = tv[i].e_emp; x.full = tv[i].e_full;
`else
      x.pc = tv[i].e_pc_n; x.emp = 1'b1; x.full = 1'b0;
`endif
      x.id = i;
      sb.push_back(x);
    end

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      check_out();
      drive(($urandom_range(0, 59) == 0),
            (($urandom_range(0, 4) == 0) ? 6'($urandom) | 6'h01 : 6'($urandom) & 6'h3E),
            $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 11) == 0),
            $urandom & 32'hFFFF_FFFC);
      x.pc = m_pc;
`ifdef PC_RAS_EN
      x.emp = (m_ras.size() == 0); x.full = (m_ras.size() == 4);
`else
      x.emp = 1'b1; x.full = 1'b0;
`endif
      x.id = 1000 + i;
      sb.push_back(x);
    end

    @(negedge clk);
    check_out();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
